w5300_rx_engine: RTL
====================

# w5300_rx_engine

Multi-socket receive engine for the W5300 Ethernet controller. It arbitrates receive interrupts from up to eight hardware sockets and reads each pending packet's size and payload through the shared register-bus controller. Payload words go into a caller-owned RX buffer under ready/valid backpressure, then the socket's RECV command is issued. Oversize packets are drained and dropped. It sits between the socket IRQ decoder and the bus controller, in place of the per-socket receiver instances.

## Interface
- NUM_SOCK, 1: number of sockets served (1..8); socket i uses index i.
- BUF_AW, 16: RX buffer word-address width.
- MAX_BYTES, 2048: largest accepted packet in bytes; larger packets are drained and dropped.
- ALIGN_MODE, 0: 0 = size read from the Sn_RX_FIFOR header word; 1 = size read from Sn_RX_RSR0/RSR2 (Sn_MR_ALIGN set).

- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- rx_irq  in  NUM_SOCK  level receive-pending flags, one per socket.
- bus_req  out  1  access request; held until bus_done.
- bus_addr  out  11  bit 10 = W5300::RD/WR op code, bits 9:0 = register from W5300::get_socket_n_reg(reg, cur_sock).
- bus_wdata  out  16  write data; 0 for reads.
- bus_rdata  in  16  read data, valid in the bus_done cycle.
- bus_done  in  1  one-cycle pulse: current access complete.
- buf_valid  out  1  payload word valid.
- buf_ready  in  1  buffer can accept a word.
- buf_addr  out  BUF_AW  word address, starting at 0 for each packet.
- buf_data  out  16  payload word.
- rx_sock  out  3  socket being or last served.
- rx_bytes  out  16  packet byte count (saturated at 16'hFFFF).
- rx_done  out  1  one-cycle pulse: packet accepted.
- rx_drop  out  1  one-cycle pulse: packet dropped (oversize).

## Operation
- States: IDLE, ARB, SIZE_HI, SIZE_LO, CALC, DATA, HOLD, CMD, FINISH.
- IDLE goes to ARB when any rx_irq bit is set.
- ARB picks the round-robin winner starting after last_sock (reset: NUM_SOCK-1, so socket 0 goes first) and latches it into cur_sock and rx_sock.
- ALIGN_MODE=1 path: SIZE_HI reads Sn_RX_RSR0, SIZE_LO reads Sn_RX_RSR2; size = {hi[0], lo}, 17 bits.
- ALIGN_MODE=0 path: SIZE_HI is skipped; SIZE_LO reads Sn_RX_FIFOR, and size = that word.
- CALC sets words = (size+1)>>1 (17-bit arithmetic) and drop = (size > MAX_BYTES). It also clears word_cnt and buf_addr.
  - If size==0: return to IDLE. No RECV, no pulse, and last_sock is updated.
- DATA reads Sn_RX_FIFOR once per word. On bus_done, the word is captured.
  - drop=0: go to HOLD, with buf_valid=1 and buf_data=captured word.
  - drop=1: no buf_valid; word_cnt increments.
- HOLD waits for buf_ready. On valid&&ready: buf_addr++, word_cnt++, and the engine returns to DATA, or goes to CMD when word_cnt+1==words.
  - No new bus read is issued while in HOLD.
- CMD writes W5300::Sn_CR_RECEIVE to Sn_CR and waits for bus_done.
- FINISH lasts one cycle: it pulses rx_done (drop=0) or rx_drop (drop=1), updates last_sock, and returns to IDLE.
- For odd sizes, the final word's low byte is don't-care. It is still written.

## Timing
- Reset values: bus_req=0, bus_addr={RD,10'h3FE}, bus_wdata=0, buf_valid=0, buf_addr=0, buf_data=0, rx_sock=0, rx_bytes=0, rx_done=0, rx_drop=0; state IDLE.
- bus_req is registered and rises the cycle after entering SIZE_HI, SIZE_LO, DATA or CMD. It falls the cycle after bus_done.
- bus_addr and bus_wdata are stable whenever bus_req=1.
- The engine ignores bus_done when no access is outstanding.
- rx_bytes updates in CALC and holds until the next CALC.
- buf_valid rises the cycle after a DATA bus_done. buf_valid, buf_addr and buf_data stay stable until accepted.
- Back-to-back throughput: one word per bus access plus 2 cycles when buf_ready is held high.
- rx_irq changes during a packet do not affect the packet in progress. Only ARB samples rx_irq.
- Assertion of rst_n mid-packet aborts immediately to reset values. No RECV is issued.

## Test plan
- NUM_SOCK=1, ALIGN_MODE=0, FIFOR header=16'd6, payload 1111/2222/3333, buf_ready=1 -> 3 buf writes at addresses 0..2, then a write of Sn_CR_RECEIVE to socket 0's Sn_CR, then rx_done with rx_bytes=6.
- Odd size 5 -> exactly 3 words read and written, rx_bytes=5.
- NUM_SOCK=4, rx_irq=4'b1010 held -> sockets served in order 1, 3, 1, 3; rx_sock matches the socket-indexed addresses on bus_addr.
- ALIGN_MODE=1, RSR0=16'h0000, RSR2=16'h0004 -> 2 FIFOR reads, RECV, rx_done.
- MAX_BYTES=8, size 10 -> 5 FIFOR reads, buf_valid never asserts, RECV issued, rx_drop pulse, no rx_done.
- buf_ready low for 7 cycles mid-packet -> buf_valid/addr/data held stable and no new bus_req during the stall; then reset asserted mid-DATA -> all outputs return to reset values.

Source files
------------

// File: rtl/w5300_rx_engine.sv
// w5300_rx_engine: round-robin multi-socket W5300 receive engine that reads packet size and payload
// over the shared register bus, streams payload words to an RX buffer and issues RECV.
module w5300_rx_engine #(
    parameter int NUM_SOCK   = 1,
    parameter int BUF_AW     = 16,
    parameter int MAX_BYTES  = 2048,
    parameter int ALIGN_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_SOCK-1:0] rx_irq,
    output logic                bus_req,
    output logic [10:0]         bus_addr,
    output logic [15:0]         bus_wdata,
    input  logic [15:0]         bus_rdata,
    input  logic                bus_done,
    output logic                buf_valid,
    input  logic                buf_ready,
    output logic [BUF_AW-1:0]   buf_addr,
    output logic [15:0]         buf_data,
    output logic [2:0]          rx_sock,
    output logic [15:0]         rx_bytes,
    output logic                rx_done,
    output logic                rx_drop
);
    localparam logic        OP_RD = 1'b0;
    localparam logic        OP_WR = 1'b1;
    localparam logic [9:0]  SN_CR = 10'h202;
    localparam logic [9:0]  SN_RX_RSR0 = 10'h228;
    localparam logic [9:0]  SN_RX_RSR2 = 10'h22A;
    localparam logic [9:0]  SN_RX_FIFOR = 10'h230;
    localparam logic [15:0] SN_CR_RECEIVE = 16'h0040;

    typedef enum logic [3:0] {IDLE, ARB, SIZE_HI, SIZE_LO, CALC, DATA, HOLD, CMD, FINISH} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cur_sock, last_sock, win;
    logic        win_ok, hi, drop, done, access, last_word;
    logic [16:0] size, words, word_cnt;
    logic [17:0] size_inc;
    logic [7:0]  irq;
    logic [9:0]  reg_sel;

    assign irq = 8'(rx_irq);
    assign done = bus_req && bus_done;
    assign access = state inside {SIZE_HI, SIZE_LO, DATA, CMD};
    assign last_word = word_cnt + 17'd1 == words;
    assign size_inc = {1'b0, size} + 18'd1;
    assign buf_valid = state == HOLD;
    assign rx_done = state == FINISH && !drop;
    assign rx_drop = state == FINISH && drop;

    always_comb begin
        reg_sel = state == SIZE_HI ? SN_RX_RSR0 :
                  state == CMD ? SN_CR :
                  state == SIZE_LO && ALIGN_MODE != 0 ? SN_RX_RSR2 : SN_RX_FIFOR;
    end

    // scan downwards so the socket nearest after last_sock is the final (winning) assignment
    always_comb begin
        win = last_sock;
        win_ok = 1'b0;
        for (int k = NUM_SOCK; k >= 1; k--) begin
            int idx;
            idx = (int'(last_sock) + k) % NUM_SOCK;
            if (irq[3'(idx)]) begin
                win = 3'(idx);
                win_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|rx_irq) state_nxt = ARB;
            ARB:     state_nxt = !win_ok ? IDLE : ALIGN_MODE != 0 ? SIZE_HI : SIZE_LO;
            SIZE_HI: if (done) state_nxt = SIZE_LO;
            SIZE_LO: if (done) state_nxt = CALC;
            CALC:    state_nxt = size == 17'd0 ? IDLE : DATA;
            DATA:    if (done) state_nxt = !drop ? HOLD : last_word ? CMD : DATA;
            HOLD:    if (buf_ready) state_nxt = last_word ? CMD : DATA;
            CMD:     if (done) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bus_req <= 1'b0;
            bus_addr <= {OP_RD, 10'h3FE};
            bus_wdata <= '0;
            buf_addr <= '0;
            buf_data <= '0;
            rx_sock <= '0;
            rx_bytes <= '0;
            cur_sock <= '0;
            last_sock <= 3'(NUM_SOCK - 1);
            hi <= 1'b0;
            size <= '0;
            words <= '0;
            word_cnt <= '0;
            drop <= 1'b0;
        end else begin
            state <= state_nxt;
            bus_req <= access && !done;
            // address and data are loaded only while idle on the bus, so they hold for the whole access
            if (access && !bus_req) begin
                bus_addr <= {state == CMD ? OP_WR : OP_RD, reg_sel + {1'b0, cur_sock, 6'd0}};
                bus_wdata <= state == CMD ? SN_CR_RECEIVE : 16'h0000;
            end
            if (state == ARB && win_ok) begin
                cur_sock <= win;
                rx_sock <= win;
            end
            if (state == SIZE_HI && done) hi <= bus_rdata[0];
            if (state == SIZE_LO && done) size <= {ALIGN_MODE != 0 && hi, bus_rdata};
            if (state == CALC) begin
                words <= size_inc[17:1];
                drop <= size > 17'(MAX_BYTES);
                word_cnt <= '0;
                buf_addr <= '0;
                rx_bytes <= size[16] ? 16'hFFFF : size[15:0];
                if (size == 17'd0) last_sock <= cur_sock;
            end
            if (state == DATA && done) buf_data <= bus_rdata;
            if (state == DATA && done && drop) word_cnt <= word_cnt + 17'd1;
            if (state == HOLD && buf_ready) begin
                buf_addr <= buf_addr + BUF_AW'(1);
                word_cnt <= word_cnt + 17'd1;
            end
            if (state == FINISH) last_sock <= cur_sock;
        end
    end
endmodule
